// File: rtl/mips_16_debug_ctrl_if.sv
// Debug host link of the 16-bit MIPS run/halt controller:
// run-control requests plus the register-file access handshake.
`timescale 1ns/1ps
interface mips_16_debug_ctrl_if;
    logic        dbg_halt_req;
    logic        dbg_run_req;
    logic        dbg_step_req;
    logic        dbg_rf_req;
    logic        dbg_rf_we;
    logic [2:0]  dbg_rf_addr;
    logic [15:0] dbg_rf_wdata;
    logic        dbg_rf_ack;
    logic [15:0] dbg_rf_rdata;

    modport master (
        output dbg_halt_req, dbg_run_req, dbg_step_req,
        output dbg_rf_req, dbg_rf_we, dbg_rf_addr, dbg_rf_wdata,
        input  dbg_rf_ack, dbg_rf_rdata
    );

    modport slave (
        input  dbg_halt_req, dbg_run_req, dbg_step_req,
        input  dbg_rf_req, dbg_rf_we, dbg_rf_addr, dbg_rf_wdata,
        output dbg_rf_ack, dbg_rf_rdata
    );
endinterface

// File: rtl/mips_16_debug_ctrl.sv
// Run/halt/single-step controller for the 16-bit MIPS pipeline, with
// arbitration of the register-file write port and read port 1 for a debug host.
`timescale 1ns/1ps
module mips_16_debug_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter bit          RESET_HALTED = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    mips_16_debug_ctrl_if.slave        dbg,
    input  logic                       wb_writ_en,
    input  logic [2:0]                 wb_writ_dest,
    input  logic [15:0]                wb_writ_data,
    input  logic [2:0]                 id_rea_addr_1,
    output logic                       rf_writ_en,
    output logic [2:0]                 rf_writ_dest,
    output logic [15:0]                rf_writ_data,
    output logic [2:0]                 rf_rea_addr_1,
    input  logic [15:0]                rf_rea_data_1,
    output logic                       core_enable,
    output logic                       halted,
    output logic [1:0]                 state,
    output logic [15:0]                run_cycles
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DATA_W = 16;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2,
        ST_STEP   = 2'd3
    } state_t;

    localparam state_t            RESET_STATE = RESET_HALTED ? ST_HALTED : ST_RUN;
    localparam logic [CNT_W-1:0]  DRAIN_LOAD  = CNT_W'(DRAIN_CYCLES - 1);

    state_t             cur_state;
    state_t             next_state;
    logic [CNT_W-1:0]   drain_cnt;
    logic [CNT_W-1:0]   next_cnt;
    logic               accept;

    // State register and drain counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= RESET_STATE;
            drain_cnt <= '0;
        end else begin
            cur_state <= next_state;
            drain_cnt <= next_cnt;
        end
    end

    // Next-state logic; DRAIN lasts DRAIN_CYCLES cycles so EX/MEM/WB retire
    always_comb begin
        next_state = cur_state;
        next_cnt   = drain_cnt;
        case (cur_state)
            ST_RUN: begin
                if (dbg.dbg_halt_req) begin
                    next_state = ST_DRAIN;
                    next_cnt   = DRAIN_LOAD;
                end
            end
            ST_STEP: begin
                next_state = ST_DRAIN;
                next_cnt   = DRAIN_LOAD;
            end
            ST_DRAIN: begin
                if (drain_cnt == '0) begin
                    next_state = ST_HALTED;
                end else begin
                    next_cnt = drain_cnt - CNT_W'(1);
                end
            end
            ST_HALTED: begin
                if (dbg.dbg_run_req) begin
                    next_state = ST_RUN;
                end else if (dbg.dbg_step_req) begin
                    next_state = ST_STEP;
                end
            end
            default: begin
                next_state = RESET_STATE;
            end
        endcase
    end

    // Outputs decoded from state, plus register-file port arbitration
    always_comb begin
        state         = cur_state;
        core_enable   = (cur_state == ST_RUN) || (cur_state == ST_STEP);
        halted        = (cur_state == ST_HALTED);
        accept        = halted && dbg.dbg_rf_req && !wb_writ_en && !dbg.dbg_rf_ack;
        rf_writ_en    = wb_writ_en;
        rf_writ_dest  = wb_writ_dest;
        rf_writ_data  = wb_writ_data;
        rf_rea_addr_1 = id_rea_addr_1;
        if (accept) begin
            rf_rea_addr_1 = dbg.dbg_rf_addr;
            if (dbg.dbg_rf_we) begin
                rf_writ_en   = 1'b1;
                rf_writ_dest = dbg.dbg_rf_addr;
                rf_writ_data = dbg.dbg_rf_wdata;
            end
        end
    end

    // Debug ack/read-data and enabled-cycle counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbg.dbg_rf_ack   <= 1'b0;
            dbg.dbg_rf_rdata <= '0;
            run_cycles       <= '0;
        end else begin
            dbg.dbg_rf_ack <= accept;
            if (accept && !dbg.dbg_rf_we) begin
                dbg.dbg_rf_rdata <= rf_rea_data_1;
            end
            if (core_enable) begin
                run_cycles <= run_cycles + DATA_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mips_16_debug_ctrl.sv
// Bench for mips_16_debug_ctrl: directed scenarios plus random traffic, every
// cycle compared against a cycle-level behavioural model of the controller.
`timescale 1ns/1ps
module tb_mips_16_debug_ctrl;

    localparam int unsigned D  = 3;
    localparam bit          RH = 1'b0;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_writ_en;
    logic [2:0]  wb_writ_dest;
    logic [15:0] wb_writ_data;
    logic [2:0]  id_rea_addr_1;
    logic        rf_writ_en;
    logic [2:0]  rf_writ_dest;
    logic [15:0] rf_writ_data;
    logic [2:0]  rf_rea_addr_1;
    logic [15:0] rf_rea_data_1;
    logic        core_enable;
    logic        halted;
    logic [1:0]  state;
    logic [15:0] run_cycles;
    logic [15:0] regs [8];

    int n_checks = 0;
    int n_pass   = 0;

    // Model: mode uses the externally visible encoding, left = DRAIN cycles remaining
    int          m_mode;
    int          m_left;
    logic [15:0] m_rc;
    logic        m_ack;
    logic [15:0] m_rdata;
    logic [15:0] m_regs [8];
    bit          pending;

    always #5 clk = ~clk;

    mips_16_debug_ctrl_if dbg ();

    mips_16_debug_ctrl #(.DRAIN_CYCLES(D), .RESET_HALTED(RH)) dut (
        .clk           (clk),
        .rst           (rst),
        .dbg           (dbg),
        .wb_writ_en    (wb_writ_en),
        .wb_writ_dest  (wb_writ_dest),
        .wb_writ_data  (wb_writ_data),
        .id_rea_addr_1 (id_rea_addr_1),
        .rf_writ_en    (rf_writ_en),
        .rf_writ_dest  (rf_writ_dest),
        .rf_writ_data  (rf_writ_data),
        .rf_rea_addr_1 (rf_rea_addr_1),
        .rf_rea_data_1 (rf_rea_data_1),
        .core_enable   (core_enable),
        .halted        (halted),
        .state         (state),
        .run_cycles    (run_cycles)
    );

    // Register file the controller talks to
    assign rf_rea_data_1 = regs[rf_rea_addr_1];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) regs[i] <= 16'h1000 + 16'(i);
        end else if (rf_writ_en) begin
            regs[rf_writ_dest] <= rf_writ_data;
        end
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_mode  = RH ? 2 : 0;
        m_left  = 0;
        m_rc    = 16'h0000;
        m_ack   = 1'b0;
        m_rdata = 16'h0000;
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h1000 + 16'(i);
    endtask

    function automatic bit model_accept();
        return (m_mode == 2) && dbg.dbg_rf_req && !wb_writ_en && !m_ack;
    endfunction

    task automatic check_all();
        bit acc, dwr, ce;
        acc = model_accept();
        dwr = acc && dbg.dbg_rf_we;
        ce  = (m_mode == 0) || (m_mode == 3);
        check("state",       16'(state),           16'(m_mode));
        check("core_enable", 16'(core_enable),     16'(ce));
        check("halted",      16'(halted),          16'(m_mode == 2));
        check("run_cycles",  run_cycles,           m_rc);
        check("rf_ack",      16'(dbg.dbg_rf_ack),  16'(m_ack));
        check("rf_rdata",    dbg.dbg_rf_rdata,     m_rdata);
        check("rf_writ_en",  16'(rf_writ_en),      16'(wb_writ_en || dwr));
        check("rf_writ_dest", 16'(rf_writ_dest),   16'(dwr ? dbg.dbg_rf_addr : wb_writ_dest));
        check("rf_writ_data", rf_writ_data,        dwr ? dbg.dbg_rf_wdata : wb_writ_data);
        check("rf_rea_addr_1", 16'(rf_rea_addr_1), 16'(acc ? dbg.dbg_rf_addr : id_rea_addr_1));
    endtask

    task automatic model_step();
        bit acc;
        acc = model_accept();
        if (acc && !dbg.dbg_rf_we) m_rdata = m_regs[dbg.dbg_rf_addr];
        if (wb_writ_en) m_regs[wb_writ_dest] = wb_writ_data;
        else if (acc && dbg.dbg_rf_we) m_regs[dbg.dbg_rf_addr] = dbg.dbg_rf_wdata;
        m_ack = acc;
        if (m_mode == 0 || m_mode == 3) m_rc = m_rc + 16'd1;
        case (m_mode)
            0: if (dbg.dbg_halt_req) begin m_mode = 1; m_left = D; end
            3: begin m_mode = 1; m_left = D; end
            1: if (m_left == 1) m_mode = 2; else m_left--;
            default: if (dbg.dbg_run_req) m_mode = 0; else if (dbg.dbg_step_req) m_mode = 3;
        endcase
    endtask

    // One clock: compare, advance model at the edge, return at the falling edge
    task automatic cycle();
        #1 check_all();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle();
        dbg.dbg_halt_req = 1'b0;
        dbg.dbg_run_req  = 1'b0;
        dbg.dbg_step_req = 1'b0;
        wb_writ_en       = 1'b0;
    endtask

    initial begin
        logic [15:0] rc0;
        int k;
        rst = 1'b1;
        idle();
        dbg.dbg_rf_req   = 1'b0;
        dbg.dbg_rf_we    = 1'b0;
        dbg.dbg_rf_addr  = 3'd0;
        dbg.dbg_rf_wdata = 16'h0;
        wb_writ_dest     = 3'd0;
        wb_writ_data     = 16'h0;
        id_rea_addr_1    = 3'd1;
        pending          = 1'b0;
        model_reset();
        #2 check_all();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) cycle();

        // Halt: DRAIN for D cycles, then HALTED
        dbg.dbg_halt_req = 1'b1;
        cycle();
        dbg.dbg_halt_req = 1'b0;
        check("halt_ce_off", 16'(core_enable), 16'd0);
        for (int i = 0; i < int'(D); i++) begin
            check("halt_drain", 16'(state), 16'd1);
            cycle();
        end
        check("halt_done", 16'(halted), 16'd1);

        // Single step
        rc0 = m_rc;
        dbg.dbg_step_req = 1'b1;
        cycle();
        dbg.dbg_step_req = 1'b0;
        check("step_state", 16'(state), 16'd3);
        check("step_ce", 16'(core_enable), 16'd1);
        cycle();
        check("step_drain", 16'(state), 16'd1);
        check("step_count", run_cycles, rc0 + 16'd1);
        repeat (D) cycle();
        check("step_halted", 16'(halted), 16'd1);
        check("step_count_hold", run_cycles, rc0 + 16'd1);

        // Debug write R5 then read it back
        dbg.dbg_rf_req = 1'b1; dbg.dbg_rf_we = 1'b1;
        dbg.dbg_rf_addr = 3'd5; dbg.dbg_rf_wdata = 16'hBEEF;
        #1 check("beef_we", 16'(rf_writ_en), 16'd1);
        check("beef_dest", 16'(rf_writ_dest), 16'd5);
        check("beef_data", rf_writ_data, 16'hBEEF);
        cycle();
        check("beef_wack", 16'(dbg.dbg_rf_ack), 16'd1);
        cycle();
        dbg.dbg_rf_req = 1'b0;
        cycle();
        dbg.dbg_rf_req = 1'b1; dbg.dbg_rf_we = 1'b0;
        #1 check("beef_raddr", 16'(rf_rea_addr_1), 16'd5);
        cycle();
        dbg.dbg_rf_req = 1'b0;
        check("beef_rack", 16'(dbg.dbg_rf_ack), 16'd1);
        check("beef_rdata", dbg.dbg_rf_rdata, 16'hBEEF);
        cycle();

        // WB write wins during DRAIN; debug read waits for HALTED
        dbg.dbg_run_req = 1'b1; cycle(); dbg.dbg_run_req = 1'b0;
        dbg.dbg_halt_req = 1'b1; cycle(); dbg.dbg_halt_req = 1'b0;
        wb_writ_en = 1'b1; wb_writ_dest = 3'd2; wb_writ_data = 16'h1234;
        dbg.dbg_rf_req = 1'b1; dbg.dbg_rf_we = 1'b0; dbg.dbg_rf_addr = 3'd2;
        #1 check("wb_pass_en", 16'(rf_writ_en), 16'd1);
        check("wb_pass_data", rf_writ_data, 16'h1234);
        k = 0;
        while (m_mode != 2 && k < 20) begin cycle(); k++; end
        wb_writ_en = 1'b0;
        k = 0;
        while (!dbg.dbg_rf_ack && k < 12) begin cycle(); k++; end
        check("wb_wait_ack", 16'(dbg.dbg_rf_ack), 16'd1);
        check("wb_wait_rdata", dbg.dbg_rf_rdata, 16'h1234);
        dbg.dbg_rf_req = 1'b0;
        cycle();

        // Run beats step; halt wins in RUN
        dbg.dbg_run_req = 1'b1; dbg.dbg_step_req = 1'b1;
        cycle();
        idle();
        check("run_over_step", 16'(state), 16'd0);
        dbg.dbg_halt_req = 1'b1; dbg.dbg_run_req = 1'b1;
        cycle();
        idle();
        check("halt_in_run", 16'(state), 16'd1);

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            dbg.dbg_halt_req = ($urandom_range(0, 99) < 8);
            dbg.dbg_run_req  = ($urandom_range(0, 99) < 5);
            dbg.dbg_step_req = ($urandom_range(0, 99) < 8);
            wb_writ_en       = ($urandom_range(0, 99) < 25);
            wb_writ_dest     = 3'($urandom);
            wb_writ_data     = 16'($urandom);
            id_rea_addr_1    = 3'($urandom);
            if (pending) begin
                if (m_ack) begin
                    pending = 1'b0;
                    dbg.dbg_rf_req = 1'($urandom_range(0, 1));
                end
            end else if ($urandom_range(0, 99) < 30) begin
                pending = 1'b1;
                dbg.dbg_rf_req   = 1'b1;
                dbg.dbg_rf_we    = 1'($urandom);
                dbg.dbg_rf_addr  = 3'($urandom);
                dbg.dbg_rf_wdata = 16'($urandom);
            end else begin
                dbg.dbg_rf_req = 1'b0;
            end
            cycle();
        end
        idle();
        dbg.dbg_rf_req = 1'b0;
        pending = 1'b0;

        // Reach DRAIN from RUN, then reset with a request outstanding
        k = 0;
        while (m_mode != 0 && k < 30) begin
            dbg.dbg_run_req = (m_mode == 2);
            cycle();
            k++;
        end
        dbg.dbg_run_req = 1'b0;
        dbg.dbg_halt_req = 1'b1;
        cycle();
        dbg.dbg_halt_req = 1'b0;
        dbg.dbg_rf_req = 1'b1; dbg.dbg_rf_we = 1'b0;
        check("pre_rst_drain", 16'(state), 16'd1);
        #2 rst = 1'b1;
        #1 check("rst_state", 16'(state), 16'd0);
        check("rst_ce", 16'(core_enable), 16'd1);
        check("rst_ack", 16'(dbg.dbg_rf_ack), 16'd0);
        check("rst_rdata", dbg.dbg_rf_rdata, 16'd0);
        check("rst_count", run_cycles, 16'd0);
        model_reset();
        dbg.dbg_rf_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Counter wrap: 0xFFFF enabled cycles, then one more
        for (int i = 0; i < 65535; i++) begin
            @(posedge clk);
            model_step();
        end
        @(negedge clk);
        check("count_max", run_cycles, 16'hFFFF);
        cycle();
        check("count_wrap", run_cycles, 16'h0000);
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
